// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM encoding, NOP word, default PC constants.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD     = 32'd0;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load captures a fetched word, flush clears only the valid bit.
// Latency 1 cycle; with neither load nor flush the contents are held (stall).
module ifid_reg
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc_plus_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      instr   <= NOP_WORD;
      pc      <= 32'd0;
      pc_plus <= 32'd0;
    end else if (flush) begin
      // Payload is left as-is; decode ignores it while valid is low.
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instr_in;
      pc      <= pc_in;
      pc_plus <= pc_plus_in;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC register, BOOT/RUN/HALTED control and IF/ID capture; latency 1 cycle, stall holds PC and IF/ID.
// Optional IF_ALIGN_CHECK_EN adds fetch_fault: misaligned redirect targets halt fetch permanently until reset.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_target,
  input  logic             halt_req,
  output logic             ifid_valid,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_pc,
  output logic [31:0]      ifid_pc_plus,
  output logic [CNT_W-1:0] fetch_count,
  output logic [1:0]       state_o
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic             fetch_fault
`endif
);

  state_t           state, state_nxt;
  logic [31:0]      pc, pc_nxt, pc_seq;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load, flush;
  logic             redir_take, redir_bad;

  assign pc_seq    = pc + PC_INC;
  assign imem_addr = pc;
  assign state_o   = state;

`ifdef IF_ALIGN_CHECK_EN
  logic fault_q;

  assign redir_bad   = redirect_valid && !fault_q && !word_aligned(redirect_target);
  assign redir_take  = redirect_valid && !fault_q && word_aligned(redirect_target);
  assign fetch_fault = fault_q;

  // BOOT ignores redirects entirely, so a bad target there is not a fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (redir_bad && state != ST_BOOT) begin
      fault_q <= 1'b1;
    end
  end
`else
  assign redir_bad  = 1'b0;
  assign redir_take = redirect_valid;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      fetch_count <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = fetch_count;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_BOOT: begin
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        // Redirect beats halt, halt beats stall, stall beats sequential fetch.
        if (redir_bad) begin
          flush     = 1'b1;
          state_nxt = ST_HALTED;
        end else if (redir_take) begin
          pc_nxt = redirect_target;
          flush  = 1'b1;
        end else if (halt_req) begin
          flush     = 1'b1;
          state_nxt = ST_HALTED;
        end else if (!stall) begin
          load    = 1'b1;
          pc_nxt  = pc_seq;
          cnt_nxt = fetch_count + CNT_W'(1);
        end
      end
      ST_HALTED: begin
        flush = 1'b1;
        if (redir_take) begin
          pc_nxt    = redirect_target;
          state_nxt = ST_RUN;
        end
      end
      default: begin
        state_nxt = ST_BOOT;
      end
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .flush      (flush),
    .instr_in   (imem_rdata),
    .pc_in      (pc),
    .pc_plus_in (pc_seq),
    .valid      (ifid_valid),
    .instr      (ifid_instr),
    .pc         (ifid_pc),
    .pc_plus    (ifid_pc_plus)
  );

endmodule
